imm_encoder: RTL and testbench
==============================

// Module: imm_encoder
// PURPOSE
//  Inverse of the immediate sign-extension stage: packs a 32-bit immediate plus
//  non-immediate instruction fields into a RISC-V instruction word. Used by the
//  instruction-memory loader and the self-check bench.
//  Elastic 2-stage valid/ready pipeline with range/alignment checking and a
//  word-address counter, so every output word carries its target address.
// PARAMETERS
//  ADDR_WIDTH  8  width of word-address counter addr; wraps at 2**ADDR_WIDTH
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst        in   1           asynchronous, active-high reset
//  in_valid   in   1           request present
//  in_ready   out  1           request accepted when in_valid && in_ready
//  ImmSrc     in   3           3'b000 I-type (addi), 3'b001 B-type (bne); others unsupported
//  ImmOp      in   32          sign-extended immediate to encode
//  base       in   32          opcode/rd/rs1/rs2/funct3; immediate bit positions ignored
//  out_valid  out  1           instr/addr valid
//  out_ready  in   1           consumer takes word when out_valid && out_ready
//  instr      out  32          encoded instruction
//  addr       out  ADDR_WIDTH  word address of instr
//  err        out  1           one-cycle pulse: request rejected
//  err_code   out  2           01 bad ImmSrc, 10 out of range, 11 B-type misaligned; held until next err
// BEHAVIOUR
//  Reset: in_ready=1 (after release), out_valid=0, instr=0, addr=0, err=0, err_code=00,
//   both stages empty; reset mid-operation drops in-flight words, no output pulse.
//  S1 registers {ImmSrc,ImmOp,base} on accept; encode+check are combinational on S1;
//   S2 registers the result. Latency: accept in cycle N -> out_valid in cycle N+2
//   if out_ready is held high; full throughput 1 word/cycle.
//  in_ready = !s1_valid || s1_moves; s1_moves = s1_err || !s2_valid || out_ready.
//  Out stalls: out_valid && !out_ready holds instr/addr stable; S1 fills then in_ready=0.
//  Encoding:
//   I: instr = {ImmOp[11:0], base[19:0]}
//   B: instr = {ImmOp[12], ImmOp[10:5], base[24:12], ImmOp[4:1], ImmOp[11], base[6:0]}
//  Checks (priority order, evaluated on S1):
//   ImmSrc not 000/001 -> code 01; I: ImmOp[31:11] not all equal -> code 10;
//   B: ImmOp[31:12] not all equal -> code 10; B: ImmOp[0]=1 -> code 11.
//   Rejected entry leaves S1 in one cycle regardless of out_ready, never reaches
//   S2, never advances addr; err=1 in the cycle after it leaves S1.
//  Round-trip invariant: sign-extending instr with the same ImmSrc returns ImmOp.
//  addr: value is the address of the word in S2; increments by 1 on each output
//   handshake; ADDR_WIDTH'(2**ADDR_WIDTH-1) + 1 wraps to 0 without flag.
//  Simultaneous: S2 output handshake and S1->S2 transfer in same cycle is legal;
//   accept into S1 in same cycle S1 empties is legal.
// TESTING
//  1 reset, ImmSrc=000 ImmOp=32'hFFFF_FFFF base=32'h0000_0513, out_ready=1
//    -> cycle+2: instr=32'hFFF0_0513 (addi a0,x0,-1), addr=0, err=0.
//  2 ImmSrc=001 ImmOp=32'hFFFF_FFF8 base=32'h0000_1063 -> instr=32'hFE00_1CE3, addr=1;
//    sign-extension of instr yields 32'hFFFF_FFF8.
//  3 ImmSrc=000 ImmOp=32'h0000_0800 -> no out_valid, err pulse, err_code=10, addr unchanged;
//    ImmSrc=001 ImmOp=3 -> err_code=11; ImmSrc=010 -> err_code=01.
//  4 stream 6 valid words with out_ready=0 for 5 cycles -> in_ready falls after 2 accepts,
//    instr/addr stable; release -> words out in order, addrs consecutive, no loss/dup.
//  5 ADDR_WIDTH=2: 5 valid words -> addr sequence 0,1,2,3,0.
//  6 assert rst with both stages full -> out_valid=0, addr=0 immediately (async);
//    after release first new word gets addr=0.

Source files
------------

// File: rtl/imm_encoder.sv
// Packs a sign-extended immediate and the non-immediate fields of a base word into a RISC-V
// instruction, through a two-stage valid/ready pipeline that tags each word with its address.
module imm_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            ImmSrc,
    input  logic [31:0]           ImmOp,
    input  logic [31:0]           base,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  err,
    output logic [1:0]            err_code
);

    logic                  r_s1Valid;
    logic [2:0]            r_s1Src;
    logic [31:0]           r_s1Imm;
    logic [31:0]           r_s1Base;
    logic                  r_s2Valid;
    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_err;
    logic [1:0]            r_errCode;

    logic [1:0]            w_code;
    logic [31:0]           w_instr;
    logic                  w_s1Err;
    logic                  w_s2Free;
    logic                  w_s1Moves;
    logic                  w_unusedBase;

    // base[31:25] never lands in either supported format.
    assign w_unusedBase = ^r_s1Base[31:25];

    always_comb begin
        w_code = 2'b00;
        if (r_s1Src == 3'b000) begin
            if (!((&r_s1Imm[31:11]) || !(|r_s1Imm[31:11])))
                w_code = 2'b10;
        end else if (r_s1Src == 3'b001) begin
            if (!((&r_s1Imm[31:12]) || !(|r_s1Imm[31:12])))
                w_code = 2'b10;
            else if (r_s1Imm[0])
                w_code = 2'b11;
        end else begin
            w_code = 2'b01;
        end
    end

    always_comb begin
        w_instr = {r_s1Imm[11:0], r_s1Base[19:0]};
        if (r_s1Src == 3'b001)
            w_instr = {r_s1Imm[12], r_s1Imm[10:5], r_s1Base[24:12],
                       r_s1Imm[4:1], r_s1Imm[11], r_s1Base[6:0]};
    end

    // A rejected entry drains from S1 even while the output stage is stalled.
    assign w_s1Err   = r_s1Valid && (w_code != 2'b00);
    assign w_s2Free  = !r_s2Valid || out_ready;
    assign w_s1Moves = w_s1Err || w_s2Free;
    assign in_ready  = !r_s1Valid || w_s1Moves;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1Src   <= 3'b000;
            r_s1Imm   <= 32'h0;
            r_s1Base  <= 32'h0;
        end else if (in_ready) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1Src  <= ImmSrc;
                r_s1Imm  <= ImmOp;
                r_s1Base <= base;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_instr   <= 32'h0;
        end else if (w_s2Free) begin
            r_s2Valid <= r_s1Valid && !w_s1Err;
            if (r_s1Valid && !w_s1Err)
                r_instr <= w_instr;
        end
    end

    // The counter always names the word sitting in S2, so it only moves on an output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_addr <= '0;
        else if (r_s2Valid && out_ready)
            r_addr <= r_addr + ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_errCode <= 2'b00;
        end else begin
            r_err <= w_s1Err;
            if (w_s1Err)
                r_errCode <= w_code;
        end
    end

    assign out_valid = r_s2Valid;
    assign instr     = r_instr;
    assign addr      = r_addr;
    assign err       = r_err;
    assign err_code  = r_errCode;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed scenarios plus a randomized stream
// scored against a decode-based reference model.
module tb_imm_encoder;

    localparam int AW = 2;

    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    ImmSrc;
    logic [31:0]   ImmOp;
    logic [31:0]   base;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   instr;
    logic [AW-1:0] addr;
    logic          err;
    logic [1:0]    err_code;

    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] expAddr = '0;

    always #5 clk = ~clk;

    imm_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ImmSrc(ImmSrc), .ImmOp(ImmOp), .base(base),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .addr(addr),
        .err(err), .err_code(err_code)
    );

    // Standard RISC-V immediate decoders: the encoder is correct if these undo it.
    function automatic logic [31:0] decodeImm(input logic [2:0] src, input logic [31:0] w);
        if (src == 3'b000)
            return {{20{w[31]}}, w[31:20]};
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] fieldMask(input logic [2:0] src);
        if (src == 3'b000)
            return 32'h000F_FFFF;
        return 32'h01FF_F07F;
    endfunction

    function automatic logic [1:0] expectCode(input logic [2:0] src, input logic [31:0] imm);
        int v;
        v = imm;
        if (src > 3'b001) return 2'b01;
        if (src == 3'b000) return (v < -2048 || v > 2047) ? 2'b10 : 2'b00;
        if (v < -4096 || v > 4095) return 2'b10;
        if (imm[0]) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [31:0] randImm();
        int v;
        int edges[9];
        edges = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, -4098, 4095};
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 4095)) - 2048;
            1: v = (int'($urandom_range(0, 4095)) - 2048) * 2;
            2: v = int'($urandom);
            default: v = edges[$urandom_range(0, 8)];
        endcase
        return v;
    endfunction

    function automatic logic [2:0] randSrc();
        int p;
        p = $urandom_range(0, 9);
        if (p < 5) return 3'b000;
        if (p < 9) return 3'b001;
        return 3'($urandom_range(2, 7));
    endfunction

    task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [31:0] i,
                                 input logic [31:0] b);
        in_valid = v;
        ImmSrc   = s;
        ImmOp    = i;
        base     = b;
    endtask

    task automatic resetDut;
        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expAddr = '0;
    endtask

    task automatic test_reset;
        resetDut();
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h want 0", instr); end
        checks++; if (addr !== '0) begin errors++; $display("[TB] FAIL reset_addr: got %0d want 0", addr); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", err); end
        checks++; if (err_code !== 2'b00) begin errors++; $display("[TB] FAIL reset_err_code: got %b want 00", err_code); end
    endtask

    task automatic test_addi;
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_0513);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL addi_accept: in_ready got %b want 1", in_ready); end
        @(posedge clk); #1 applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL addi_latency_n1: out_valid got %b want 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addi_latency_n2: out_valid got %b want 1", out_valid); end
        checks++; if (instr !== 32'hFFF0_0513) begin errors++; $display("[TB] FAIL addi_instr: got %h want fff00513", instr); end
        checks++; if (addr !== 2'd0) begin errors++; $display("[TB] FAIL addi_addr: got %0d want 0", addr); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL addi_err: got %b want 0", err); end
        expAddr = expAddr + AW'(1);
    endtask

    task automatic test_bne;
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 3'b001, 32'hFFFF_FFF8, 32'h0000_1063);
        @(posedge clk); #1 applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bne_valid: got %b want 1", out_valid); end
        checks++; if (instr !== 32'hFE00_1CE3) begin errors++; $display("[TB] FAIL bne_instr: got %h want fe001ce3", instr); end
        checks++; if (addr !== 2'd1) begin errors++; $display("[TB] FAIL bne_addr: got %0d want 1", addr); end
        checks++; if (decodeImm(3'b001, instr) !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL bne_roundtrip: got %h want fffffff8", decodeImm(3'b001, instr)); end
        expAddr = expAddr + AW'(1);
    endtask

    task automatic test_errors;
        logic [2:0]  srcs[3];
        logic [31:0] imms[3];
        logic [1:0]  codes[3];
        logic [4:0]  errBits;
        logic [1:0]  codeAt2;
        logic        sawOut;
        srcs  = '{3'b000, 3'b001, 3'b010};
        imms  = '{32'h0000_0800, 32'h0000_0003, 32'h0000_0000};
        codes = '{2'b10, 2'b11, 2'b01};
        for (int k = 0; k < 3; k++) begin
            errBits = '0;
            codeAt2 = 2'b00;
            sawOut  = 1'b0;
            @(posedge clk); #1;
            out_ready = 1'b1;
            applyStimulus(1'b1, srcs[k], imms[k], 32'h0000_0013);
            @(negedge clk);
            @(posedge clk); #1 applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
            for (int j = 1; j <= 4; j++) begin
                @(negedge clk);
                if (err) errBits[j] = 1'b1;
                if (out_valid) sawOut = 1'b1;
                if (j == 2) codeAt2 = err_code;
            end
            checks++; if (errBits !== 5'b00100) begin errors++; $display("[TB] FAIL err_pulse[%0d]: cycles %b want 00100", k, errBits); end
            checks++; if (codeAt2 !== codes[k]) begin errors++; $display("[TB] FAIL err_code[%0d]: got %b want %b", k, codeAt2, codes[k]); end
            checks++; if (err_code !== codes[k]) begin errors++; $display("[TB] FAIL err_code_held[%0d]: got %b want %b", k, err_code, codes[k]); end
            checks++; if (sawOut !== 1'b0) begin errors++; $display("[TB] FAIL err_no_output[%0d]: out_valid seen %b want 0", k, sawOut); end
            checks++; if (addr !== expAddr) begin errors++; $display("[TB] FAIL err_addr[%0d]: got %0d want %0d", k, addr, expAddr); end
        end
    endtask

    task automatic test_backpressure;
        req_t          words[6];
        int            idx = 0;
        int            outIdx = 0;
        int            accepts = 0;
        logic [31:0]   holdInstr = '0;
        logic [AW-1:0] holdAddr = '0;
        for (int i = 0; i < 6; i++) begin
            words[i].src  = (i % 2 == 0) ? 3'b000 : 3'b001;
            words[i].imm  = (i % 2 == 0) ? 32'(int'($urandom_range(0, 4095)) - 2048)
                                         : 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            words[i].base = $urandom;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(1'b1, words[0].src, words[0].imm, words[0].base);
        for (int c = 0; c < 60 && outIdx < 6; c++) begin
            @(negedge clk);
            if (c == 2) begin
                holdInstr = instr;
                holdAddr  = addr;
            end
            if (c == 4) begin
                checks++; if (accepts !== 2) begin errors++; $display("[TB] FAIL bp_accepts: got %0d want 2", accepts); end
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); end
                checks++; if (out_valid !== 1'b1 || instr !== holdInstr || addr !== holdAddr) begin
                    errors++; $display("[TB] FAIL bp_stable: got v=%b %h/%0d want v=1 %h/%0d", out_valid, instr, addr, holdInstr, holdAddr);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (decodeImm(words[outIdx].src, instr) !== words[outIdx].imm ||
                    (instr & fieldMask(words[outIdx].src)) !== (words[outIdx].base & fieldMask(words[outIdx].src)) ||
                    addr !== expAddr) begin
                    errors++;
                    $display("[TB] FAIL bp_word[%0d]: got instr=%h addr=%0d want imm=%h base=%h addr=%0d",
                             outIdx, instr, addr, words[outIdx].imm, words[outIdx].base, expAddr);
                end
                expAddr = expAddr + AW'(1);
                outIdx++;
            end
            if (in_valid && in_ready) begin
                accepts++;
                idx++;
            end
            @(posedge clk); #1;
            out_ready = (c >= 4);
            if (idx < 6) applyStimulus(1'b1, words[idx].src, words[idx].imm, words[idx].base);
            else         applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
        end
        checks++; if (outIdx !== 6) begin errors++; $display("[TB] FAIL bp_drain: got %0d words want 6", outIdx); end
    endtask

    task automatic test_addr_wrap;
        int seen = 0;
        int sent = 0;
        int want[5];
        want = '{0, 1, 2, 3, 0};
        resetDut();
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 3'b000, 32'h0000_0010, 32'h0000_0093);
        for (int c = 0; c < 30 && seen < 5; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                checks++; if (addr !== AW'(want[seen])) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %0d want %0d", seen, addr, want[seen]); end
                seen++;
                expAddr = expAddr + AW'(1);
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            if (sent < 5) applyStimulus(1'b1, 3'b000, 32'(sent + 16), 32'h0000_0093);
            else          applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
        end
        checks++; if (seen !== 5) begin errors++; $display("[TB] FAIL wrap_count: got %0d words want 5", seen); end
    endtask

    task automatic test_async_reset;
        int n = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(1'b1, 3'b000, 32'h0000_0005, 32'h0000_0113);
        @(posedge clk); #1 applyStimulus(1'b1, 3'b000, 32'h0000_0006, 32'h0000_0113);
        @(posedge clk); #1 applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || addr !== 2'd1) begin
            errors++; $display("[TB] FAIL areset_pre: got v=%b rdy=%b addr=%0d want v=1 rdy=0 addr=1", out_valid, in_ready, addr);
        end
        @(posedge clk); #3 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || addr !== '0 || instr !== 32'h0) begin
            errors++; $display("[TB] FAIL areset_immediate: got v=%b addr=%0d instr=%h want 0/0/0", out_valid, addr, instr);
        end
        @(posedge clk); #1 rst = 1'b0;
        expAddr = '0;
        out_ready = 1'b1;
        applyStimulus(1'b1, 3'b001, 32'hFFFF_F000, 32'h0020_8063);
        @(posedge clk); #1 applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL areset_timeout: out_valid got %b want 1", out_valid); end
        checks++; if (addr !== '0 || decodeImm(3'b001, instr) !== 32'hFFFF_F000) begin
            errors++; $display("[TB] FAIL areset_first_word: got addr=%0d imm=%h want 0 fffff000", addr, decodeImm(3'b001, instr));
        end
        expAddr = expAddr + AW'(1);
        @(posedge clk); #1;
    endtask

    task automatic test_random_stream;
        req_t q[$];
        req_t r;
        int   rejects = 0;
        int   pulses = 0;
        @(negedge clk);
        @(posedge clk); #1;
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (err) pulses++;
            if (in_valid && in_ready) begin
                r.src = ImmSrc; r.imm = ImmOp; r.base = base;
                if (expectCode(r.src, r.imm) == 2'b00) q.push_back(r);
                else rejects++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("[TB] FAIL rand_spurious: got instr=%h want no word", instr);
                end else begin
                    r = q.pop_front();
                    if (decodeImm(r.src, instr) !== r.imm ||
                        (instr & fieldMask(r.src)) !== (r.base & fieldMask(r.src)) || addr !== expAddr) begin
                        errors++;
                        $display("[TB] FAIL rand_word: got instr=%h addr=%0d want src=%0d imm=%h base=%h addr=%0d",
                                 instr, addr, r.src, r.imm, r.base, expAddr);
                    end
                end
                expAddr = expAddr + AW'(1);
            end
            @(posedge clk); #1;
            if (c < 400) begin
                out_ready = ($urandom_range(0, 3) != 0);
                applyStimulus(1'($urandom_range(0, 1)), randSrc(), randImm(), $urandom);
            end else begin
                out_ready = 1'b1;
                applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
            end
        end
        checks++; if (q.size() !== 0) begin errors++; $display("[TB] FAIL rand_leftover: got %0d words pending want 0", q.size()); end
        checks++; if (pulses !== rejects) begin errors++; $display("[TB] FAIL rand_err_pulses: got %0d want %0d", pulses, rejects); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bne();
        test_errors();
        test_backpressure();
        test_addr_wrap();
        test_async_reset();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
